// File: rtl/shift_seq_unit.sv
// ============================================================================
// Module   : shift_seq_unit
// Purpose  : Multi-mode sequential shifter (LSL/LSR/ASR/ROL/ROR/NOP),
//            one bit position per clock, with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq_unit #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int unsigned      AMT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             carry_q, carry_d;
    logic [AMT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       mode_q,  mode_d;

    logic [WIDTH-1:0] step_data;
    logic             step_carry;
    logic             last_step;

    assign last_step = (cnt_q == AMT_W'(1));

    // Result of a single one-bit step in the latched mode; NOP modes hold.
    always_comb begin
        step_data  = data_q;
        step_carry = carry_q;
        case (mode_q)
            MODE_LSL: begin
                step_data  = {data_q[WIDTH-2:0], serial_in};
                step_carry = data_q[WIDTH-1];
            end
            MODE_LSR: begin
                step_data  = {serial_in, data_q[WIDTH-1:1]};
                step_carry = data_q[0];
            end
            MODE_ASR: begin
                step_data  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                step_carry = data_q[0];
            end
            MODE_ROL: begin
                step_data  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                step_carry = data_q[WIDTH-1];
            end
            MODE_ROR: begin
                step_data  = {data_q[0], data_q[WIDTH-1:1]};
                step_carry = data_q[0];
            end
            default: begin
                step_data  = data_q;
                step_carry = carry_q;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load has priority over start in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!load && start) begin
                    state_d = (amount == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state
    always_comb begin
        data_d  = data_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    data_d  = data_in;
                    carry_d = 1'b0;
                end else if (start) begin
                    mode_d = mode;
                    cnt_d  = amount;
                end
            end
            S_SHIFT: begin
                data_d  = step_data;
                carry_d = step_carry;
                cnt_d   = cnt_q - AMT_W'(1);
            end
            default: begin
                data_d  = data_q;
                carry_d = carry_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            data_q  <= RST_VAL;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= MODE_LSL;
        end else begin
            data_q  <= data_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Output decode
    always_comb begin
        data_out = data_q;
        carry    = carry_q;
        busy     = (state_q == S_SHIFT);
        done     = (state_q == S_DONE);
    end

endmodule

`default_nettype wire
